// File: rtl/banco_registros_param.sv
// Parametrised register bank: two combinational read ports, one synchronous
// write port, optional hardwired-zero R0, write-to-read bypass, per-register
// pending scoreboard and a multi-cycle clear sweep.
module banco_registros_param #(
    parameter int BITS_PALAVRA  = 16,
    parameter int NUM_REGISTROS = 4,
    parameter int ZERO_REG      = 0,
    parameter int BYPASS        = 1,
    localparam int END_REGISTROS = $clog2(NUM_REGISTROS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     hab_escrita,
    input  logic [END_REGISTROS-1:0] sel_sc,
    input  logic [BITS_PALAVRA-1:0]  e,
    input  logic [END_REGISTROS-1:0] sel_sa,
    input  logic [END_REGISTROS-1:0] sel_sb,
    output logic [BITS_PALAVRA-1:0]  a,
    output logic [BITS_PALAVRA-1:0]  b,
    input  logic                     reserva,
    input  logic [END_REGISTROS-1:0] sel_rd,
    output logic                     pend_a,
    output logic                     pend_b,
    input  logic                     limpa,
    output logic                     pronto,
    output logic                     escrita_perd
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        LIMPANDO = 1'b1
    } estado_t;

    localparam logic [END_REGISTROS-1:0] ULTIMO   = END_REGISTROS'(NUM_REGISTROS - 1);
    localparam logic [END_REGISTROS-1:0] END_ZERO = {END_REGISTROS{1'b0}};
    localparam logic [END_REGISTROS-1:0] END_UM   = END_REGISTROS'(1);

    logic [BITS_PALAVRA-1:0]  regs_q [NUM_REGISTROS];
    logic [BITS_PALAVRA-1:0]  regs_d [NUM_REGISTROS];
    logic [NUM_REGISTROS-1:0] pend_q;
    logic [NUM_REGISTROS-1:0] pend_d;
    estado_t                  estado_q;
    estado_t                  estado_d;
    logic [END_REGISTROS-1:0] cont_q;
    logic [END_REGISTROS-1:0] cont_d;
    logic                     perd_q;
    logic                     perd_d;
    logic                     byp_a_s;
    logic                     byp_b_s;

    // True when the address names the hardwired-zero register.
    function automatic logic eh_zero(input logic [END_REGISTROS-1:0] sel);
        return (ZERO_REG != 0) && (sel == END_ZERO);
    endfunction

    // Next-state logic: writes, reservations and the clear sweep sequencing.
    always_comb begin
        estado_d = estado_q;
        cont_d   = cont_q;
        perd_d   = 1'b0;
        pend_d   = pend_q;
        for (int i = 0; i < NUM_REGISTROS; i++) begin
            regs_d[i] = regs_q[i];
        end
        case (estado_q)
            IDLE: begin
                for (int i = 0; i < NUM_REGISTROS; i++) begin
                    // A write commits even on the cycle the sweep starts.
                    regs_d[i] = (hab_escrita && (sel_sc == END_REGISTROS'(i)) && !eh_zero(sel_sc))
                              ? e : regs_q[i];
                    // Clear-all beats reservation, reservation beats write-release.
                    pend_d[i] = limpa ? 1'b0
                              : (reserva && (sel_rd == END_REGISTROS'(i)) && !eh_zero(sel_rd)) ? 1'b1
                              : (hab_escrita && (sel_sc == END_REGISTROS'(i))) ? 1'b0
                              : pend_q[i];
                end
                if (limpa) begin
                    estado_d = LIMPANDO;
                    cont_d   = END_ZERO;
                end else begin
                    estado_d = IDLE;
                    cont_d   = cont_q;
                end
            end
            LIMPANDO: begin
                for (int i = 0; i < NUM_REGISTROS; i++) begin
                    regs_d[i] = (cont_q == END_REGISTROS'(i)) ? {BITS_PALAVRA{1'b0}} : regs_q[i];
                end
                // Writes arriving during the sweep are dropped and flagged.
                perd_d = hab_escrita;
                // Counter wraps to zero naturally after the last register.
                cont_d = cont_q + END_UM;
                if (cont_q == ULTIMO) begin
                    estado_d = IDLE;
                end else begin
                    estado_d = LIMPANDO;
                end
            end
            default: begin
                estado_d = IDLE;
                cont_d   = END_ZERO;
            end
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGISTROS; i++) begin
                regs_q[i] <= {BITS_PALAVRA{1'b0}};
            end
            pend_q   <= {NUM_REGISTROS{1'b0}};
            estado_q <= IDLE;
            cont_q   <= END_ZERO;
            perd_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGISTROS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_q   <= pend_d;
            estado_q <= estado_d;
            cont_q   <= cont_d;
            perd_q   <= perd_d;
        end
    end

    // Combinational read ports with optional same-cycle forwarding.
    always_comb begin
        byp_a_s = (BYPASS != 0) && (estado_q == IDLE) && hab_escrita && (sel_sc == sel_sa);
        byp_b_s = (BYPASS != 0) && (estado_q == IDLE) && hab_escrita && (sel_sc == sel_sb);
        if (eh_zero(sel_sa)) begin
            a = {BITS_PALAVRA{1'b0}};
        end else if (byp_a_s) begin
            a = e;
        end else begin
            a = regs_q[sel_sa];
        end
        if (eh_zero(sel_sb)) begin
            b = {BITS_PALAVRA{1'b0}};
        end else if (byp_b_s) begin
            b = e;
        end else begin
            b = regs_q[sel_sb];
        end
    end

    // Scoreboard and status outputs (pending bits are never forwarded).
    always_comb begin
        pend_a       = eh_zero(sel_sa) ? 1'b0 : pend_q[sel_sa];
        pend_b       = eh_zero(sel_sb) ? 1'b0 : pend_q[sel_sb];
        pronto       = (estado_q == IDLE);
        escrita_perd = perd_q;
    end

endmodule

// File: tb/tb_banco_registros_param.sv
// Bench for banco_registros_param: instance 1 uses the default configuration
// (16 bit, 4 regs, no zero register, bypass on); instance 2 uses 32 bit,
// 16 regs, hardwired R0, bypass off. Table vectors, hand sequences and a
// random phase checked against an array-based reference model.
module tb_banco_registros_param;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // Instance 1 signals
    logic        h1, res1, lim1;
    logic [1:0]  sc1, sa1, sb1, rd1;
    logic [15:0] e1, a1, b1;
    logic        pa1, pb1, pr1, ep1;
    // Instance 2 signals
    logic        h2, res2, lim2;
    logic [3:0]  sc2, sa2, sb2, rd2;
    logic [31:0] e2, a2, b2;
    logic        pa2, pb2, pr2, ep2;

    banco_registros_param #(.BITS_PALAVRA(16), .NUM_REGISTROS(4), .ZERO_REG(0), .BYPASS(1)) dut1 (
        .clock(clock), .reset(reset), .hab_escrita(h1), .sel_sc(sc1), .e(e1),
        .sel_sa(sa1), .sel_sb(sb1), .a(a1), .b(b1), .reserva(res1), .sel_rd(rd1),
        .pend_a(pa1), .pend_b(pb1), .limpa(lim1), .pronto(pr1), .escrita_perd(ep1));

    banco_registros_param #(.BITS_PALAVRA(32), .NUM_REGISTROS(16), .ZERO_REG(1), .BYPASS(0)) dut2 (
        .clock(clock), .reset(reset), .hab_escrita(h2), .sel_sc(sc2), .e(e2),
        .sel_sa(sa2), .sel_sb(sb2), .a(a2), .b(b2), .reserva(res2), .sel_rd(rd2),
        .pend_a(pa2), .pend_b(pb2), .limpa(lim2), .pronto(pr2), .escrita_perd(ep2));

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    logic [31:0] m_mem  [2][16];
    bit          m_pend [2][16];
    bit          m_busy [2];
    int          m_idx  [2];
    bit          m_perd [2];

    function automatic int nreg(int c); return (c == 0) ? 4 : 16; endfunction
    function automatic bit zr(int c);   return c == 1; endfunction
    function automatic bit byp(int c);  return c == 0; endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 16; i++) begin
                m_mem[c][i]  = 32'h0;
                m_pend[c][i] = 1'b0;
            end
            m_busy[c] = 1'b0;
            m_idx[c]  = 0;
            m_perd[c] = 1'b0;
        end
    endtask

    function automatic logic [31:0] exp_rd(int c, int sa, bit we, int sc, logic [31:0] ev);
        if (zr(c) && sa == 0) return 32'h0;
        if (byp(c) && !m_busy[c] && we && sc == sa) return ev;
        return m_mem[c][sa];
    endfunction

    function automatic bit exp_pend(int c, int sa);
        if (zr(c) && sa == 0) return 1'b0;
        return m_pend[c][sa];
    endfunction

    task automatic model_edge(int c, bit we, int sc, logic [31:0] ev, bit res, int rd, bit lim);
        if (!m_busy[c]) begin
            m_perd[c] = 1'b0;
            if (we) begin
                if (!(zr(c) && sc == 0)) m_mem[c][sc] = ev;
                m_pend[c][sc] = 1'b0;
            end
            if (res && !(zr(c) && rd == 0)) m_pend[c][rd] = 1'b1;
            if (lim) begin
                for (int i = 0; i < 16; i++) m_pend[c][i] = 1'b0;
                m_busy[c] = 1'b1;
                m_idx[c]  = 0;
            end
        end else begin
            m_perd[c] = we;
            m_mem[c][m_idx[c]] = 32'h0;
            m_idx[c]++;
            if (m_idx[c] == nreg(c)) m_busy[c] = 1'b0;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("m1_a",    {16'h0, a1}, exp_rd(0, sa1, h1, sc1, {16'h0, e1}));
        chk("m1_b",    {16'h0, b1}, exp_rd(0, sb1, h1, sc1, {16'h0, e1}));
        chk("m1_pa",   {31'h0, pa1}, {31'h0, exp_pend(0, sa1)});
        chk("m1_pb",   {31'h0, pb1}, {31'h0, exp_pend(0, sb1)});
        chk("m1_pr",   {31'h0, pr1}, {31'h0, !m_busy[0]});
        chk("m1_perd", {31'h0, ep1}, {31'h0, m_perd[0]});
        chk("m2_a",    a2, exp_rd(1, sa2, h2, sc2, e2));
        chk("m2_b",    b2, exp_rd(1, sb2, h2, sc2, e2));
        chk("m2_pa",   {31'h0, pa2}, {31'h0, exp_pend(1, sa2)});
        chk("m2_pb",   {31'h0, pb2}, {31'h0, exp_pend(1, sb2)});
        chk("m2_pr",   {31'h0, pr2}, {31'h0, !m_busy[1]});
        chk("m2_perd", {31'h0, ep2}, {31'h0, m_perd[1]});
    endtask

    // Called shortly after a negedge with inputs already set.
    task automatic step();
        #1;
        check_all();
        @(posedge clock);
        model_edge(0, h1, sc1, {16'h0, e1}, res1, rd1, lim1);
        model_edge(1, h2, sc2, e2, res2, rd2, lim2);
        @(negedge clock);
    endtask

    task automatic idle_all();
        h1 = 1'b0; res1 = 1'b0; lim1 = 1'b0; sc1 = 2'd0; sa1 = 2'd0; sb1 = 2'd0; rd1 = 2'd0; e1 = 16'h0;
        h2 = 1'b0; res2 = 1'b0; lim2 = 1'b0; sc2 = 4'd0; sa2 = 4'd0; sb2 = 4'd0; rd2 = 4'd0; e2 = 32'h0;
    endtask

    // Asynchronous reset pulse inside the low clock phase (no clock edge).
    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_pronto1", {31'h0, pr1}, 32'h1);
        chk("rst_pronto2", {31'h0, pr2}, 32'h1);
        check_all();
        reset = 1'b1;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        bit          we;
        logic [1:0]  sc;
        logic [15:0] ev;
        logic [1:0]  sa;
        logic [1:0]  sb;
        bit          res;
        logic [1:0]  rd;
        logic [15:0] xa;
        logic [15:0] xb;
        bit          xpa;
        bit          xpb;
    } vec_t;

    function automatic vec_t mk(bit we, logic [1:0] sc, logic [15:0] ev, logic [1:0] sa, logic [1:0] sb,
                                bit res, logic [1:0] rd, logic [15:0] xa, logic [15:0] xb, bit xpa, bit xpb);
        vec_t v;
        v.we = we; v.sc = sc; v.ev = ev; v.sa = sa; v.sb = sb; v.res = res; v.rd = rd;
        v.xa = xa; v.xb = xb; v.xpa = xpa; v.xpb = xpb;
        return v;
    endfunction

    vec_t tbl [11];

    initial begin
        int cnt;
        bit done;
        tbl[0]  = mk(1'b1, 2'd2, 16'hBEEF, 2'd0, 2'd1, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 2'd3, 16'h1111, 2'd2, 2'd3, 1'b0, 2'd0, 16'hBEEF, 16'h1111, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 2'd0, 16'h0000, 2'd3, 2'd2, 1'b0, 2'd0, 16'h1111, 16'hBEEF, 1'b0, 1'b0);
        tbl[3]  = mk(1'b0, 2'd0, 16'h0000, 2'd1, 2'd1, 1'b1, 2'd1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 2'd0, 16'h0000, 2'd1, 2'd2, 1'b0, 2'd0, 16'h0000, 16'hBEEF, 1'b1, 1'b0);
        tbl[5]  = mk(1'b1, 2'd1, 16'hAAAA, 2'd1, 2'd0, 1'b0, 2'd0, 16'hAAAA, 16'h0000, 1'b1, 1'b0);
        tbl[6]  = mk(1'b0, 2'd0, 16'h0000, 2'd1, 2'd1, 1'b0, 2'd0, 16'hAAAA, 16'hAAAA, 1'b0, 1'b0);
        tbl[7]  = mk(1'b1, 2'd1, 16'h5555, 2'd1, 2'd2, 1'b1, 2'd1, 16'h5555, 16'hBEEF, 1'b0, 1'b0);
        tbl[8]  = mk(1'b0, 2'd0, 16'h0000, 2'd1, 2'd0, 1'b0, 2'd0, 16'h5555, 16'h0000, 1'b1, 1'b0);
        tbl[9]  = mk(1'b1, 2'd0, 16'h1234, 2'd0, 2'd0, 1'b0, 2'd0, 16'h1234, 16'h1234, 1'b0, 1'b0);
        tbl[10] = mk(1'b0, 2'd0, 16'h0000, 2'd0, 2'd3, 1'b0, 2'd0, 16'h1234, 16'h1111, 1'b0, 1'b0);

        idle_all();
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        do_reset();

        // Table-driven vectors on instance 1
        for (int i = 0; i < 11; i++) begin
            h1 = tbl[i].we; sc1 = tbl[i].sc; e1 = tbl[i].ev; sa1 = tbl[i].sa; sb1 = tbl[i].sb;
            res1 = tbl[i].res; rd1 = tbl[i].rd;
            #1;
            chk($sformatf("tbl%0d_a", i),  {16'h0, a1}, {16'h0, tbl[i].xa});
            chk($sformatf("tbl%0d_b", i),  {16'h0, b1}, {16'h0, tbl[i].xb});
            chk($sformatf("tbl%0d_pa", i), {31'h0, pa1}, {31'h0, tbl[i].xpa});
            chk($sformatf("tbl%0d_pb", i), {31'h0, pb1}, {31'h0, tbl[i].xpb});
            step();
        end
        idle_all();

        // Sweep on instance 1: load 1..4, clear, watch order and dropped write
        for (int i = 0; i < 4; i++) begin
            h1 = 1'b1; sc1 = 2'(i); e1 = 16'(i + 1);
            step();
        end
        h1 = 1'b0; lim1 = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            sa1 = 2'(k); sb1 = 2'd3; h1 = (k == 1); sc1 = 2'd3; e1 = 16'hFFFF; lim1 = 1'b1;
            #1;
            chk($sformatf("sw%0d_pronto", k), {31'h0, pr1}, 32'h0);
            chk($sformatf("sw%0d_a", k), {16'h0, a1}, 32'(k + 1));
            chk($sformatf("sw%0d_b_nobyp", k), {16'h0, b1}, 32'h4);
            chk($sformatf("sw%0d_perd", k), {31'h0, ep1}, (k == 2) ? 32'h1 : 32'h0);
            step();
        end
        idle_all();
        for (int i = 0; i < 4; i++) begin
            sa1 = 2'(i);
            #1;
            chk("sw_done_pronto", {31'h0, pr1}, 32'h1);
            chk($sformatf("sw_done_r%0d", i), {16'h0, a1}, 32'h0);
            step();
        end

        // Reset at cycle 2 of a sweep
        h1 = 1'b1; sc1 = 2'd2; e1 = 16'h0007; step();
        h1 = 1'b1; sc1 = 2'd3; e1 = 16'h0009; step();
        h1 = 1'b0; lim1 = 1'b1; step();
        lim1 = 1'b0; step();
        step();
        sa1 = 2'd2; sb1 = 2'd3;
        #1;
        chk("rs_pre_a", {16'h0, a1}, 32'h7);
        chk("rs_pre_pronto", {31'h0, pr1}, 32'h0);
        do_reset();
        chk("rs_a", {16'h0, a1}, 32'h0);
        chk("rs_b", {16'h0, b1}, 32'h0);
        step();
        idle_all();

        // Instance 2: hardwired R0, no bypass
        h2 = 1'b1; sc2 = 4'd0; e2 = 32'h1234; sa2 = 4'd0; step();
        h2 = 1'b0; res2 = 1'b1; rd2 = 4'd0;
        #1; chk("z_r0_read", a2, 32'h0);
        step();
        res2 = 1'b0;
        #1; chk("z_r0_pend", {31'h0, pa2}, 32'h0);
        h2 = 1'b1; sc2 = 4'd3; e2 = 32'hCAFEF00D; sb2 = 4'd3;
        #1; chk("nobyp_old", b2, 32'h0);
        step();
        h2 = 1'b0;
        #1; chk("nobyp_new", b2, 32'hCAFEF00D);
        step();
        for (int i = 0; i < 16; i++) begin
            h2 = 1'b1; sc2 = 4'(i); e2 = 32'(i) * 32'h01010101 + 32'h5;
            step();
        end
        h2 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sa2 = 4'(i); sb2 = 4'(15 - i);
            #1;
            chk($sformatf("s16_a%0d", i), a2, (i == 0) ? 32'h0 : 32'(i) * 32'h01010101 + 32'h5);
            chk($sformatf("s16_b%0d", i), b2, (i == 15) ? 32'h0 : 32'(15 - i) * 32'h01010101 + 32'h5);
            step();
        end
        lim2 = 1'b1; step();
        lim2 = 1'b0;
        cnt = 0; done = 1'b0;
        for (int g = 0; g < 100 && !done; g++) begin
            #1;
            if (pr2) done = 1'b1;
            else cnt++;
            step();
        end
        chk("s16_sweep_len", 32'(cnt), 32'd16);
        idle_all();

        // Randomised phase on both instances
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(399) == 0) begin
                idle_all();
                do_reset();
            end
            h1 = ($urandom_range(1) == 1); sc1 = 2'($urandom_range(3)); e1 = 16'($urandom);
            sa1 = 2'($urandom_range(3)); sb1 = 2'($urandom_range(3));
            res1 = ($urandom_range(3) == 0); rd1 = 2'($urandom_range(3)); lim1 = ($urandom_range(39) == 0);
            h2 = ($urandom_range(1) == 1); sc2 = 4'($urandom_range(15)); e2 = $urandom;
            sa2 = 4'($urandom_range(15)); sb2 = 4'($urandom_range(15));
            res2 = ($urandom_range(3) == 0); rd2 = 4'($urandom_range(15)); lim2 = ($urandom_range(59) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
